// File: rtl/pipe_ctrl_if.sv
// Pipeline control bundle: per-stage requests in, per-stage stall/flush and occupancy out.
interface pipe_ctrl_if #(
  parameter int STAGES = 6
);
  logic [STAGES-1:0] stallreq;
  logic [STAGES-1:0] flushreq;
  logic [STAGES-1:0] stall;
  logic [STAGES-1:0] flush;
  logic [STAGES-1:0] stage_valid;

  modport master (
    output stallreq, flushreq,
    input  stall, flush, stage_valid
  );

  modport slave (
    input  stallreq, flushreq,
    output stall, flush, stage_valid
  );
endinterface

// File: rtl/pipe_ctrl.sv
// Pipeline stall/flush arbiter with occupancy tracking and a stall watchdog.
// Define PIPE_CTRL_PERF_EN to build the stall-cycle and flush performance counters.
module pipe_ctrl #(
  parameter int STAGES = 6,
  parameter int WDOG_W = 8,
  parameter int CNT_W  = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  pipe_ctrl_if.slave        pif,
  input  logic              wdog_clr,
  output logic              wdog_hit,
  output logic [CNT_W-1:0]  perf_stall_cyc,
  output logic [CNT_W-1:0]  perf_flush_cnt
);

  localparam logic [WDOG_W-1:0] WDOG_MAX = '1;

  logic [STAGES-1:0] stall_m;
  logic [STAGES-1:0] flush_m;
  logic [STAGES-1:0] elig;
  logic [STAGES-1:0] bubble;
  logic [STAGES-1:0] st;
  logic [STAGES-1:0] fl;
  logic              acc;
  logic              flush_by_req;

  logic [STAGES-1:0] valid;
  logic [WDOG_W-1:0] wdog_cnt;
  logic [WDOG_W-1:0] wdog_nxt;
  logic              wdog_set;

  // stall_m/flush_m are suffix-ORs: bit j set when a request exists at or above j.
  always_comb begin
    stall_m = '0;
    flush_m = '0;
    elig    = '0;
    bubble  = '0;
    st      = '0;
    fl      = '0;
    acc     = 1'b0;
    for (int j = STAGES - 1; j >= 0; j--) begin
      acc        = acc | pif.stallreq[j];
      stall_m[j] = acc;
    end
    // A redirect from a frozen stage cannot take effect this cycle.
    elig = pif.flushreq & ~stall_m;
    acc  = 1'b0;
    for (int j = STAGES - 1; j >= 1; j--) begin
      acc        = acc | elig[j];
      flush_m[j] = acc;
    end
    for (int j = 1; j < STAGES; j++) begin
      bubble[j] = stall_m[j-1] & ~stall_m[j];
    end
    st = stall_m & ~flush_m;
    fl = flush_m | bubble;
    if (!rst_n) begin
      st = '0;
      fl = '0;
    end
  end

  assign flush_by_req    = flush_m[1] & rst_n;
  assign pif.stall       = st;
  assign pif.flush       = fl;
  assign pif.stage_valid = valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid <= '0;
    end else begin
      valid[0] <= 1'b1;
      for (int k = 1; k < STAGES; k++) begin
        if (fl[k]) begin
          valid[k] <= 1'b0;
        end else if (!st[k]) begin
          valid[k] <= valid[k-1];
        end
      end
    end
  end

  // The flag rises on the same edge the counter lands on its saturated value.
  always_comb begin
    wdog_nxt = '0;
    if (st[0]) begin
      wdog_nxt = (wdog_cnt == WDOG_MAX) ? WDOG_MAX : wdog_cnt + 1'b1;
    end
  end

  assign wdog_set = (wdog_nxt == WDOG_MAX);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wdog_cnt <= '0;
      wdog_hit <= 1'b0;
    end else begin
      wdog_cnt <= wdog_nxt;
      if (wdog_set) begin
        wdog_hit <= 1'b1;
      end else if (wdog_clr) begin
        wdog_hit <= 1'b0;
      end
    end
  end

`ifdef PIPE_CTRL_PERF_EN
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [CNT_W-1:0] stall_cyc;
  logic [CNT_W-1:0] flush_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cyc <= '0;
      flush_cnt <= '0;
    end else begin
      if (st[0] && stall_cyc != CNT_MAX) begin
        stall_cyc <= stall_cyc + 1'b1;
      end
      if (flush_by_req && flush_cnt != CNT_MAX) begin
        flush_cnt <= flush_cnt + 1'b1;
      end
    end
  end

  assign perf_stall_cyc = stall_cyc;
  assign perf_flush_cnt = flush_cnt;
`else
  assign perf_stall_cyc = '0;
  assign perf_flush_cnt = '0;
`endif

endmodule
